hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline hazard and stall controller for the 5-stage RISC-V pipeline. It drives the stall (hold) and flush (clear) controls of the F/D, D/E, E/M and M/W pipeline registers and the E-stage forwarding selects. It also sequences data-memory wait states through a small FSM, including a wait-timeout fault, and keeps saturating stall and flush statistics counters. It sits beside the datapath in the CPU top level, with one output per pipeline-register control pin.

## Interface
- MAX_WAIT, 15: max consecutive memory-wait cycles tolerated before fault (1..255)
- CNT_W, 16: width of statistics counters
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  5  source regs of instruction in D
- Rs1E, Rs2E, RdE  in  5  source/dest regs of instruction in E
- RdM, RdW  in  5  dest regs in M, W
- RegWriteM, RegWriteW  in  1  writeback enables in M, W
- LoadE  in  1  instruction in E is a load
- PCSrcE  in  1  taken branch/jump resolved in E
- MemReqM, MemReadyM  in  1  data-memory request / ready handshake in M
- StallF, StallD, StallE, StallM  out  1  hold PC / F-D / D-E / E-M register (1 = hold; drives register EN)
- FlushD, FlushE, FlushW  out  1  clear F-D / D-E / M-W register (drives Clr)
- ForwardAE, ForwardBE  out  2  operand select: 00 regfile, 01 W result, 10 M ALU result
- Fault  out  1  sticky memory-timeout fault
- StallCount, FlushCount  out  CNT_W  saturating event counters

## Operation
- Forwarding (combinational): ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E; else 01 if RegWriteW & RdW!=0 & RdW==Rs1E; else 00. ForwardBE is the same using Rs2E. M has priority over W.
- lwStall = LoadE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- memStall = MemReqM & ~MemReadyM.
- FSM states: RUN, WAIT, FAULT. Reset enters RUN.
  - RUN: memStall -> WAIT with WaitCnt=1. Otherwise stay, WaitCnt=0.
  - WAIT: ~memStall -> RUN, WaitCnt=0. memStall & WaitCnt==MAX_WAIT -> FAULT. Otherwise WaitCnt+1.
  - FAULT: absorbing until rst.
- Output priority: FAULT > memStall > PCSrcE > lwStall.
  - FAULT: StallF/D/E/M=1, FlushW=1, all other flushes 0, Fault=1.
  - memStall (RUN or WAIT): StallF/D/E/M=1, FlushW=1 (bubble into W), FlushD=FlushE=0. A pending branch/load hazard is held frozen and is resolved in the first non-stalled cycle.
  - Otherwise:
    - StallF = lwStall & ~PCSrcE
    - StallD = lwStall & ~PCSrcE
    - FlushD = PCSrcE
    - FlushE = lwStall | PCSrcE
    - StallE = StallM = FlushW = 0
- Counters: StallCount +1 on every cycle where any of StallF..StallM is 1. FlushCount +1 on every cycle where FlushD or FlushE is 1. Both saturate at all-ones and do not wrap. Both count while in FAULT per the same rules.

## Timing
- Stall, flush and forward outputs are combinational from inputs and state, valid in the same cycle. Hazard-to-control latency is 0 cycles.
- State, WaitCnt, Fault and counters are registered and update on rising clk.
- Reset (rst=0, asynchronous, any time, including mid-WAIT): state=RUN, WaitCnt=0, Fault=0, StallCount=FlushCount=0. Combinational outputs then follow the inputs under RUN rules.
- Timeout: MAX_WAIT+1 consecutive memStall cycles drive the FSM to FAULT, and Fault=1 in the next cycle.
- A single ready cycle (MemReadyM=1) returns the FSM to RUN and resets WaitCnt.
- MemReadyM=1 in the same cycle as MemReqM produces no stall and no state change.
- PCSrcE & lwStall in the same cycle: branch wins, so the PC is not held; FlushD=1 and FlushE=1.
- Writes to x0 (Rd=0) never forward and never cause lwStall.

## Structure
- Shared package cpu_pkg holds:
  - state enum {RUN, WAIT, FAULT}
  - forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10
- Sub-module forwarding_unit, purely combinational, instantiated twice (operands A and B).
- The FSM, priority logic and counters stay in hazard_controller.

## Test plan
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. Drop RegWriteM -> 01. Set RdM=RdW=0 -> 00.
- Load-use: LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=1, FlushE=1 for one cycle. Add PCSrcE=1 -> StallF=StallD=0, FlushD=FlushE=1.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then ready -> StallF..StallM=1 and FlushW=1 for 3 cycles; FSM back in RUN; StallCount=3.
- Timeout with MAX_WAIT=4: 5 consecutive wait cycles -> Fault=1 in cycle 6 and all stalls stay 1 even after MemReadyM=1. rst=0 -> Fault=0, state RUN.
- Branch under memory stall: PCSrcE=1 during memStall -> FlushD=FlushE=0 while stalled; FlushD=FlushE=1 in the first ready cycle.
- Saturation with CNT_W=4: 20 flush cycles -> FlushCount=15. Async reset mid-WAIT -> counters 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipeline control logic.
// Holds the memory-wait FSM state encoding and the E-stage forwarding selects.
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        WAIT  = 2'b01,
        FAULT = 2'b10
    } state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Wide enough for the largest supported wait limit (255).
    localparam int WAITCNT_W = 8;

endpackage

// File: rtl/forwarding_unit.sv
// Operand forwarding select for one E-stage source register.
// The M-stage ALU result has priority over the W-stage result; x0 never forwards.
module forwarding_unit
    import cpu_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
            fwd_sel = FWD_M;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
            fwd_sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard/stall controller: forwarding selects, load-use and branch
// handling, data-memory wait sequencing with timeout fault, and event counters.
module hazard_controller
    import cpu_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             LoadE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             Fault,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam logic [WAITCNT_W-1:0] WAIT_LIMIT = WAITCNT_W'(MAX_WAIT);

    state_t                 state_reg;
    state_t                 state_next;
    logic [WAITCNT_W-1:0]   wait_cnt_reg;
    logic [WAITCNT_W-1:0]   wait_cnt_next;

    logic                   lw_stall;
    logic                   mem_stall;
    logic [1:0][4:0]        rs_e;
    logic [1:0][1:0]        fwd_sel;
    logic [1:0]             cnt_inc;

    // ------------------------------------------------------------------
    // Forwarding: one unit per E-stage operand (A = Rs1E, B = Rs2E)
    // ------------------------------------------------------------------
    assign rs_e = {Rs2E, Rs1E};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_fwd
            forwarding_unit u_fwd (
                .rs_e        (rs_e[gi]),
                .rd_m        (RdM),
                .rd_w        (RdW),
                .reg_write_m (RegWriteM),
                .reg_write_w (RegWriteW),
                .fwd_sel     (fwd_sel[gi])
            );
        end
    endgenerate

    assign ForwardAE = fwd_sel[0];
    assign ForwardBE = fwd_sel[1];

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign lw_stall  = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign mem_stall = MemReqM && !MemReadyM;

    // ------------------------------------------------------------------
    // Memory-wait FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            RUN: begin
                if (mem_stall) begin
                    state_next    = WAIT;
                    wait_cnt_next = WAITCNT_W'(1);
                end else begin
                    wait_cnt_next = '0;
                end
            end
            WAIT: begin
                if (!mem_stall) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg == WAIT_LIMIT) begin
                    state_next    = FAULT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAITCNT_W'(1);
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    assign Fault = (state_reg == FAULT);

    // ------------------------------------------------------------------
    // Stall / flush priority: fault, then memory wait, then branch, then load-use
    // ------------------------------------------------------------------
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if ((state_reg == FAULT) || mem_stall) begin
            // Freeze everything up to M and push a bubble into W; any pending
            // branch or load-use hazard is resolved once the freeze lifts.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = lw_stall && !PCSrcE;
            StallD = lw_stall && !PCSrcE;
            FlushD = PCSrcE;
            FlushE = lw_stall || PCSrcE;
        end
    end

    // ------------------------------------------------------------------
    // Saturating statistics counters (0 = stall events, 1 = flush events)
    // ------------------------------------------------------------------
    assign cnt_inc[0] = StallF || StallD || StallE || StallM;
    assign cnt_inc[1] = FlushD || FlushE;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign StallCount = gen_cnt[0].cnt_reg;
    assign FlushCount = gen_cnt[1].cnt_reg;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: a driver issues per-cycle stimulus and
// queues the reference-model expectation; a monitor pops and compares each cycle.
module tb_hazard_controller;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;
    localparam int CMAX     = (1 << CNT_W) - 1;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwm, rww, loade, pcsrc, req, rdy, rstn;
    } stim_t;

    typedef struct {
        logic [6:0] ctl;   // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
        logic [3:0] fwd;   // {ForwardAE,ForwardBE}
        logic       fault;
        int         sc;
        int         fc;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic             RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM;
    logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             Fault;
    logic [CNT_W-1:0] StallCount, FlushCount;

    hazard_controller #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RdM        (RdM),
        .RdW        (RdW),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .LoadE      (LoadE),
        .PCSrcE     (PCSrcE),
        .MemReqM    (MemReqM),
        .MemReadyM  (MemReadyM),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushW     (FlushW),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .Fault      (Fault),
        .StallCount (StallCount),
        .FlushCount (FlushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   txn   = 0;

    // Reference model state: length of the current memory-wait streak,
    // sticky fault, and the two event tallies.
    int   m_streak = 0;
    bit   m_fault  = 1'b0;
    int   m_sc     = 0;
    int   m_fc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s txn=%0d actual=%0h required=%0h", name, txn, act, exp);
        end
    endtask

    function automatic logic [1:0] fwd_of(input logic [4:0] rs, input stim_t s);
        if (s.rwm && s.rdm != 0 && s.rdm == rs) return 2'b10;
        if (s.rww && s.rdw != 0 && s.rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.rs1d = 0; s.rs2d = 0; s.rs1e = 0; s.rs2e = 0;
        s.rde = 0; s.rdm = 0; s.rdw = 0;
        s.rwm = 0; s.rww = 0; s.loade = 0; s.pcsrc = 0;
        s.req = 0; s.rdy = 0; s.rstn = 1;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        bit   mem, lw, frozen;
        @(posedge clk);
        #2;
        Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e;
        RdE = s.rde; RdM = s.rdm; RdW = s.rdw;
        RegWriteM = s.rwm; RegWriteW = s.rww; LoadE = s.loade; PCSrcE = s.pcsrc;
        MemReqM = s.req; MemReadyM = s.rdy; rst = s.rstn;
        if (!s.rstn) begin
            m_streak = 0; m_fault = 0; m_sc = 0; m_fc = 0;
        end
        mem    = s.req && !s.rdy;
        lw     = s.loade && s.rde != 0 && (s.rde == s.rs1d || s.rde == s.rs2d);
        frozen = m_fault || mem;
        if (frozen) e.ctl = 7'b1111_001;
        else        e.ctl = {lw && !s.pcsrc, lw && !s.pcsrc, 1'b0, 1'b0,
                             s.pcsrc, lw || s.pcsrc, 1'b0};
        e.fwd   = {fwd_of(s.rs1e, s), fwd_of(s.rs2e, s)};
        e.fault = m_fault;
        e.sc    = m_sc;
        e.fc    = m_fc;
        q.push_back(e);
        if (s.rstn) begin
            if (e.ctl[6:3] != 0 && m_sc < CMAX) m_sc++;
            if ((e.ctl[2] || e.ctl[1]) && m_fc < CMAX) m_fc++;
            if (!m_fault) begin
                m_streak = mem ? m_streak + 1 : 0;
                if (m_streak > MAX_WAIT) m_fault = 1'b1;
            end
        end
    endtask

    task automatic repeat_drive(input stim_t s, input int n);
        for (int i = 0; i < n; i++) drive(s);
    endtask

    task automatic do_reset();
        stim_t s;
        s = idle();
        s.rstn = 0;
        drive(s);
    endtask

    // Monitor: one expectation per cycle, compared on the falling edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                txn++;
                chk("ctl", {25'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, {25'd0, e.ctl});
                chk("fwd", {28'd0, ForwardAE, ForwardBE}, {28'd0, e.fwd});
                chk("fault", {31'd0, Fault}, {31'd0, e.fault});
                chk("stall_cnt", {28'd0, StallCount}, e.sc);
                chk("flush_cnt", {28'd0, FlushCount}, e.fc);
                $display("[TB] txn=%0d ctl=%b fwd=%b fault=%0b cnt=%0d/%0d",
                         txn, e.ctl, e.fwd, e.fault, e.sc, e.fc);
            end
        end
    end

    initial begin : driver
        stim_t s;
        int    guard;
        rst = 1'b0;
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; LoadE = 0; PCSrcE = 0; MemReqM = 0; MemReadyM = 0;

        do_reset();
        do_reset();

        // Forwarding: M beats W, then W alone, then x0 never forwards
        s = idle();
        s.rdm = 5; s.rwm = 1; s.rdw = 5; s.rww = 1; s.rs1e = 5; s.rs2e = 5;
        drive(s);
        s.rwm = 0;
        drive(s);
        s.rdm = 0; s.rdw = 0; s.rwm = 1;
        drive(s);
        s = idle();
        s.rdm = 3; s.rwm = 1; s.rdw = 9; s.rww = 1; s.rs1e = 9; s.rs2e = 3;
        drive(s);

        // Load-use, then load-use together with a taken branch
        s = idle();
        s.loade = 1; s.rde = 7; s.rs2d = 7;
        drive(s);
        s.pcsrc = 1;
        drive(s);
        s = idle();
        s.loade = 1; s.rde = 0; s.rs1d = 0;
        drive(s);

        // Memory wait of 3 cycles, then ready
        do_reset();
        s = idle();
        s.req = 1; s.rdy = 0;
        repeat_drive(s, 3);
        s.rdy = 1;
        drive(s);
        drive(idle());

        // Timeout: MAX_WAIT+1 wait cycles, fault sticks through ready
        do_reset();
        s = idle();
        s.req = 1; s.rdy = 0;
        repeat_drive(s, MAX_WAIT + 1);
        s.rdy = 1;
        repeat_drive(s, 2);
        drive(idle());
        do_reset();
        drive(idle());

        // Branch held under memory stall, resolved in the first ready cycle
        s = idle();
        s.req = 1; s.rdy = 0; s.pcsrc = 1;
        repeat_drive(s, 2);
        s.rdy = 1;
        drive(s);

        // Flush counter saturation
        do_reset();
        s = idle();
        s.pcsrc = 1;
        repeat_drive(s, 20);

        // Asynchronous reset mid-WAIT clears state without a clock edge
        s = idle();
        s.req = 1; s.rdy = 0;
        repeat_drive(s, 2);
        #4;
        rst = 1'b0;
        #1;
        chk("async_fault", {31'd0, Fault}, 32'd0);
        chk("async_stall_cnt", {28'd0, StallCount}, 32'd0);
        chk("async_flush_cnt", {28'd0, FlushCount}, 32'd0);
        s.rstn = 0;
        drive(s);
        drive(idle());

        // Randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            s.rs1d  = 5'($urandom_range(0, 3));
            s.rs2d  = 5'($urandom_range(0, 3));
            s.rs1e  = 5'($urandom_range(0, 3));
            s.rs2e  = 5'($urandom_range(0, 3));
            s.rde   = 5'($urandom_range(0, 3));
            s.rdm   = 5'($urandom_range(0, 3));
            s.rdw   = 5'($urandom_range(0, 3));
            s.rwm   = 1'($urandom_range(0, 1));
            s.rww   = 1'($urandom_range(0, 1));
            s.loade = 1'($urandom_range(0, 1));
            s.pcsrc = ($urandom_range(0, 3) == 0);
            s.req   = ($urandom_range(0, 2) != 0);
            s.rdy   = ($urandom_range(0, 9) < 3);
            s.rstn  = ($urandom_range(0, 39) != 0);
            drive(s);
        end

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk);
        if (q.size() > 0) begin
            fails++;
            $display("[TB] FAIL drain pending=%0d required=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
